tpu_control_coordinator: RTL and testbench

- Sits between the look-ahead buffer and the three execution controllers: weight load, matrix multiply and activation.
- Takes one instruction at a time from the buffer, decodes the opcode, and dispatches it in order to the target unit once that unit is free.
- Handles SYNC and NOP instructions itself and applies back-pressure to the buffer through instr_busy.

---
 rtl/tpu_control_coordinator.sv | 255 +++++++++++++++++++++++++
 tb/tb_tpu_control_coordinator.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_control_coordinator.sv
// tpu_control_coordinator
//
// In-order dispatcher between the look-ahead buffer and the weight load,
// matrix multiply and activation controllers. One instruction is held at a
// time, decoded, and issued to its unit once that unit is free. SYNC waits
// for all units to go idle and pulses synchronize. NOP and illegal opcodes
// are consumed locally, and illegal opcodes set a sticky flag.
//
// Optional feature macro: TPU_CC_PERF_COUNTERS_EN (adds stall_cycles and
// dispatched_count saturating counters).
//
// Ports:
//   clk, rst                     clock, async active-low reset
//   enable                       global run enable (0 freezes all state)
//   instr_in / instr_en          instruction from buffer / valid
//   instr_busy                   back-pressure to buffer
//   weight_/matmul_/act_instr    instruction to each unit (held until next)
//   weight_/matmul_/act_en       one-cycle dispatch strobes
//   weight_/matmul_/act_busy     unit busy inputs
//   synchronize                  one-cycle pulse on SYNC completion
//   illegal_opcode               sticky illegal opcode flag

package tpu_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  flags;
        logic [15:0] addr;
    } instr_type;

    localparam instr_type INIT_INSTR = '0;
endpackage

module tpu_control_coordinator
    import tpu_pkg::*;
#(
    parameter logic [7:0]  SYNC_OPCODE        = 8'hFF,
    parameter logic [7:0]  NOP_OPCODE         = 8'h00,
    parameter int unsigned ISSUE_GUARD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  instr_type   instr_in,
    input  logic        instr_en,
    output logic        instr_busy,
    output instr_type   weight_instr,
    output logic        weight_en,
    input  logic        weight_busy,
    output instr_type   matmul_instr,
    output logic        matmul_en,
    input  logic        matmul_busy,
    output instr_type   act_instr,
    output logic        act_en,
    input  logic        act_busy,
    output logic        synchronize,
    output logic        illegal_opcode
`ifdef TPU_CC_PERF_COUNTERS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] dispatched_count
`endif
);

    typedef enum logic [2:0] {
        ClsNop, ClsSync, ClsWeight, ClsMatmul, ClsAct, ClsIllegal
    } instr_class_e;

    typedef enum logic {StIdle, StSyncWait} state_e;

    // Unit index order: 0 weight, 1 matmul, 2 activation.
    localparam logic [1:0] GuardLoad = 2'(ISSUE_GUARD_CYCLES);

    state_e          state_q, state_d;
    logic            hold_valid_q, hold_valid_d;
    instr_type       hold_q, hold_d;
    logic [2:0][1:0] guard_q, guard_d;
    logic [2:0]      en_q, en_d;
    instr_type       weight_instr_q, weight_instr_d;
    instr_type       matmul_instr_q, matmul_instr_d;
    instr_type       act_instr_q, act_instr_d;
    logic            sync_q, sync_d;
    logic            illegal_q, illegal_d;

    instr_class_e    cls;
    logic [2:0]      unit_busy;
    logic [2:0]      unit_free;
    logic [2:0]      unit_sel;
    logic [2:0]      dispatch_unit;
    logic            target_free;
    logic            dispatch_ok;
    logic            capture;
    logic            sync_take;
    logic            sync_done;

    assign unit_busy = {act_busy, matmul_busy, weight_busy};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            unit_free[i] = ~unit_busy[i] & (guard_q[i] == 2'd0);
        end
    end

    // Opcode decode; SYNC/NOP take priority over the bit-field classes.
    always_comb begin
        cls = ClsIllegal;
        if (hold_q.opcode == SYNC_OPCODE) begin
            cls = ClsSync;
        end else if (hold_q.opcode == NOP_OPCODE) begin
            cls = ClsNop;
        end else if (hold_q.opcode[7]) begin
            cls = ClsAct;
        end else if (hold_q.opcode[7:3] == 5'b00001) begin
            cls = ClsWeight;
        end else if (hold_q.opcode[7:5] == 3'b001) begin
            cls = ClsMatmul;
        end
    end

    always_comb begin
        unit_sel    = 3'b000;
        target_free = 1'b0;
        unique case (cls)
            ClsWeight: begin
                unit_sel    = 3'b001;
                target_free = unit_free[0];
            end
            ClsMatmul: begin
                unit_sel    = 3'b010;
                target_free = unit_free[1];
            end
            ClsAct: begin
                unit_sel    = 3'b100;
                target_free = unit_free[2];
            end
            ClsNop, ClsIllegal: target_free = 1'b1;
            default:            target_free = 1'b0;
        endcase
    end

    assign dispatch_ok   = hold_valid_q & (state_q == StIdle) & enable & target_free;
    assign dispatch_unit = dispatch_ok ? unit_sel : 3'b000;
    assign instr_busy    = ~enable | (hold_valid_q & ~dispatch_ok) | (state_q == StSyncWait);
    assign capture       = enable & instr_en & ~instr_busy;
    assign sync_take     = enable & hold_valid_q & (state_q == StIdle) & (cls == ClsSync);
    assign sync_done     = enable & (state_q == StSyncWait) & (&unit_free);

    always_comb begin
        state_d        = state_q;
        hold_valid_d   = hold_valid_q;
        hold_d         = hold_q;
        guard_d        = guard_q;
        weight_instr_d = weight_instr_q;
        matmul_instr_d = matmul_instr_q;
        act_instr_d    = act_instr_q;
        illegal_d      = illegal_q | (dispatch_ok & (cls == ClsIllegal));
        // Strobes are not frozen by enable so a pulse can never repeat.
        en_d           = dispatch_unit;
        sync_d         = sync_done;

        if (dispatch_ok || sync_take) begin
            hold_valid_d = 1'b0;
        end
        if (capture) begin
            hold_valid_d = 1'b1;
            hold_d       = instr_in;
        end

        if (enable) begin
            for (int i = 0; i < 3; i++) begin
                if (dispatch_unit[i]) begin
                    guard_d[i] = GuardLoad;
                end else if (guard_q[i] != 2'd0) begin
                    guard_d[i] = guard_q[i] - 2'd1;
                end
            end
        end

        if (dispatch_unit[0]) weight_instr_d = hold_q;
        if (dispatch_unit[1]) matmul_instr_d = hold_q;
        if (dispatch_unit[2]) act_instr_d    = hold_q;

        if (sync_take) begin
            state_d = StSyncWait;
        end else if (sync_done) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            hold_valid_q   <= 1'b0;
            hold_q         <= INIT_INSTR;
            guard_q        <= '0;
            en_q           <= 3'b000;
            weight_instr_q <= INIT_INSTR;
            matmul_instr_q <= INIT_INSTR;
            act_instr_q    <= INIT_INSTR;
            sync_q         <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_valid_q   <= hold_valid_d;
            hold_q         <= hold_d;
            guard_q        <= guard_d;
            en_q           <= en_d;
            weight_instr_q <= weight_instr_d;
            matmul_instr_q <= matmul_instr_d;
            act_instr_q    <= act_instr_d;
            sync_q         <= sync_d;
            illegal_q      <= illegal_d;
        end
    end

    // Pulses are masked by enable so dropping enable cuts them off at once.
    assign weight_en      = en_q[0] & enable;
    assign matmul_en      = en_q[1] & enable;
    assign act_en         = en_q[2] & enable;
    assign synchronize    = sync_q & enable;
    assign weight_instr   = weight_instr_q;
    assign matmul_instr   = matmul_instr_q;
    assign act_instr      = act_instr_q;
    assign illegal_opcode = illegal_q;

`ifdef TPU_CC_PERF_COUNTERS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] disp_cnt_q, disp_cnt_d;

    always_comb begin
        stall_d    = stall_q;
        disp_cnt_d = disp_cnt_q;
        if (enable && ((hold_valid_q && !dispatch_ok) || (state_q == StSyncWait))
            && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        if ((|dispatch_unit) && (disp_cnt_q != 32'hFFFF_FFFF)) begin
            disp_cnt_d = disp_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q    <= '0;
            disp_cnt_q <= '0;
        end else begin
            stall_q    <= stall_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    assign stall_cycles     = stall_q;
    assign dispatched_count = disp_cnt_q;
`endif

endmodule

// File: tb/tb_tpu_control_coordinator.sv
// Self-checking bench for tpu_control_coordinator: a decode vector table plus
// hand-written multi-cycle sequences. Dispatch strobes are checked against a
// scoreboard queue filled when each instruction is driven.

module tb_tpu_control_coordinator;
    import tpu_pkg::*;

    logic      clk;
    logic      rst;
    logic      enable;
    instr_type instr_in;
    logic      instr_en;
    logic      instr_busy;
    instr_type weight_instr;
    logic      weight_en;
    logic      weight_busy;
    instr_type matmul_instr;
    logic      matmul_en;
    logic      matmul_busy;
    instr_type act_instr;
    logic      act_en;
    logic      act_busy;
    logic      synchronize;
    logic      illegal_opcode;
`ifdef TPU_CC_PERF_COUNTERS_EN
    logic [31:0] stall_cycles;
    logic [31:0] dispatched_count;
`endif

    tpu_control_coordinator dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .instr_in       (instr_in),
        .instr_en       (instr_en),
        .instr_busy     (instr_busy),
        .weight_instr   (weight_instr),
        .weight_en      (weight_en),
        .weight_busy    (weight_busy),
        .matmul_instr   (matmul_instr),
        .matmul_en      (matmul_en),
        .matmul_busy    (matmul_busy),
        .act_instr      (act_instr),
        .act_en         (act_en),
        .act_busy       (act_busy),
        .synchronize    (synchronize),
        .illegal_opcode (illegal_opcode)
`ifdef TPU_CC_PERF_COUNTERS_EN
        ,
        .stall_cycles     (stall_cycles),
        .dispatched_count (dispatched_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // unit: 0 weight, 1 matmul, 2 activation, 3 synchronize
    typedef struct packed {
        logic [1:0] unit;
        logic [7:0] op;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [7:0] op;
        int         unit;   // -1: no strobe expected
        logic       ill;    // illegal_opcode expected afterwards
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic instr_type mk(input logic [7:0] op);
        instr_type t;
        t.opcode = op;
        t.flags  = ~op;
        t.addr   = {op, 8'h5A};
        return t;
    endfunction

    task automatic sb_pop(input logic [1:0] unit, input logic [7:0] op);
        sb_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got strobe unit %0d op %0h, expected none", unit, op);
        end else begin
            e = sb.pop_front();
            check("sb_unit", 32'(unit), 32'(e.unit));
            check("sb_op", 32'(op), 32'(e.op));
        end
    endtask

    // Strobe monitor, sampling 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            if (weight_en)   sb_pop(2'd0, weight_instr.opcode);
            if (matmul_en)   sb_pop(2'd1, matmul_instr.opcode);
            if (act_en)      sb_pop(2'd2, act_instr.opcode);
            if (synchronize) sb_pop(2'd3, 8'hFF);
        end
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!instr_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL wait_ready: got instr_busy 1 for 20 cycles, expected 0");
        end
    endtask

    // Drive one instruction for one capture edge; returns at posedge+1.
    task automatic send(input logic [7:0] op);
        instr_in = mk(op);
        instr_en = 1'b1;
        @(posedge clk);
        #1;
        instr_en = 1'b0;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{8'h08, 0, 1'b0};
        vecs[1]  = '{8'h0F, 0, 1'b0};
        vecs[2]  = '{8'h20, 1, 1'b0};
        vecs[3]  = '{8'h3F, 1, 1'b0};
        vecs[4]  = '{8'h80, 2, 1'b0};
        vecs[5]  = '{8'hFE, 2, 1'b0};
        vecs[6]  = '{8'h00, -1, 1'b0};
        vecs[7]  = '{8'h40, -1, 1'b1};
        vecs[8]  = '{8'h08, 0, 1'b1};
        vecs[9]  = '{8'h10, -1, 1'b1};
        vecs[10] = '{8'h01, -1, 1'b1};

        rst         = 1'b0;
        enable      = 1'b1;
        instr_in    = mk(8'h00);
        instr_en    = 1'b0;
        weight_busy = 1'b0;
        matmul_busy = 1'b0;
        act_busy    = 1'b0;

        // Reset state
        #1;
        check("rst_busy", 32'(instr_busy), 32'd0);
        check("rst_en", 32'({weight_en, matmul_en, act_en}), 32'd0);
        check("rst_sync", 32'(synchronize), 32'd0);
        check("rst_ill", 32'(illegal_opcode), 32'd0);
        check("rst_winstr", weight_instr, 32'd0);
        check("rst_minstr", matmul_instr, 32'd0);
        check("rst_ainstr", act_instr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single weight load: strobe on the edge after capture
        sb.push_back('{2'd0, 8'h08});
        check("s1_busy_pre", 32'(instr_busy), 32'd0);
        send(8'h08);
        check("s1_no_early", 32'(weight_en), 32'd0);
        check("s1_busy_hold", 32'(instr_busy), 32'd0);
        post_edge();
        check("s1_wen", 32'(weight_en), 32'd1);
        check("s1_winstr", weight_instr, mk(8'h08));
        check("s1_busy_disp", 32'(instr_busy), 32'd0);
        post_edge();
        check("s1_wen_low", 32'(weight_en), 32'd0);

        // Decode table
        for (int v = 0; v < 11; v++) begin
            wait_ready();
            if (vecs[v].unit >= 0) sb.push_back('{2'(vecs[v].unit), vecs[v].op});
            send(vecs[v].op);
            repeat (4) @(negedge clk);
            check($sformatf("tbl%0d_sb_empty", v), 32'(sb.size()), 32'd0);
            check($sformatf("tbl%0d_ill", v), 32'(illegal_opcode), 32'(vecs[v].ill));
        end

        // Back-to-back 20, 80, 20 with matmul busy after first dispatch
        wait_ready();
        instr_in = mk(8'h20);
        instr_en = 1'b1;
        sb.push_back('{2'd1, 8'h20});
        post_edge();
        instr_in = mk(8'h80);
        sb.push_back('{2'd2, 8'h80});
        post_edge();
        check("s2_men1", 32'(matmul_en), 32'd1);
        check("s2_aen_early", 32'(act_en), 32'd0);
        instr_in = mk(8'h20);
        sb.push_back('{2'd1, 8'h20});
        matmul_busy = 1'b1;
        post_edge();
        instr_en = 1'b0;
        check("s2_aen", 32'(act_en), 32'd1);
        check("s2_men_off", 32'(matmul_en), 32'd0);
        check("s2_busy_blk", 32'(instr_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            post_edge();
            check("s2_busy_wait", 32'(instr_busy), 32'd1);
            check("s2_men_wait", 32'(matmul_en), 32'd0);
        end
        matmul_busy = 1'b0;
        #1;
        check("s2_busy_free", 32'(instr_busy), 32'd0);
        post_edge();
        check("s2_men2", 32'(matmul_en), 32'd1);
        post_edge();
        check("s2_men2_low", 32'(matmul_en), 32'd0);
        check("s2_sb_empty", 32'(sb.size()), 32'd0);

        // SYNC while activation busy
        wait_ready();
        act_busy = 1'b1;
        sb.push_back('{2'd3, 8'hFF});
        send(8'hFF);
        check("s3_busy0", 32'(instr_busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            post_edge();
            check("s3_busy", 32'(instr_busy), 32'd1);
            check("s3_nosync", 32'(synchronize), 32'd0);
        end
        act_busy = 1'b0;
        #1;
        check("s3_busy_wait", 32'(instr_busy), 32'd1);
        post_edge();
        check("s3_sync", 32'(synchronize), 32'd1);
        check("s3_busy_after", 32'(instr_busy), 32'd0);
        post_edge();
        check("s3_sync_low", 32'(synchronize), 32'd0);

        // enable low while an instruction is held
        wait_ready();
        weight_busy = 1'b1;
        sb.push_back('{2'd0, 8'h08});
        send(8'h08);
        check("s5_held", 32'(instr_busy), 32'd1);
        enable      = 1'b0;
        weight_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            post_edge();
            check("s5_wen_off", 32'(weight_en), 32'd0);
            check("s5_busy_off", 32'(instr_busy), 32'd1);
        end
        enable = 1'b1;
        #1;
        check("s5_busy_on", 32'(instr_busy), 32'd0);
        post_edge();
        check("s5_wen", 32'(weight_en), 32'd1);
        check("s5_winstr", weight_instr, mk(8'h08));

        // Asynchronous reset mid-cycle with a held instruction and matmul_en high
        wait_ready();
        wait_ready();
        instr_in = mk(8'h20);
        instr_en = 1'b1;
        sb.push_back('{2'd1, 8'h20});
        post_edge();
        instr_in = mk(8'h24);
        post_edge();
        instr_en    = 1'b0;
        matmul_busy = 1'b1;
        check("s6_men", 32'(matmul_en), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("s6_men_cut", 32'(matmul_en), 32'd0);
        check("s6_busy", 32'(instr_busy), 32'd0);
        check("s6_minstr", matmul_instr, 32'd0);
        check("s6_winstr", weight_instr, 32'd0);
        check("s6_ill", 32'(illegal_opcode), 32'd0);
        sb.delete();
        @(negedge clk);
        rst         = 1'b1;
        matmul_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            post_edge();
            check("s6_discarded", 32'(matmul_en), 32'd0);
        end
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
